// File: rtl/riscv_defines.sv
// riscv_defines
// Definitions shared by the interrupt dispatcher slice:
//   IRQ_ID_W   width of the interrupt id seen by the core
//   IRQ_LEV_W  width of a per-line priority level
//   IRQ_IDX_W  width of a line index (cfg_idx_i, prio tree result)
//   cfg_sel_e  target of a configuration write
//   irq_state_e dispatcher offer state machine
package riscv_defines;

  localparam int IRQ_ID_W  = 10;
  localparam int IRQ_LEV_W = 8;
  localparam int IRQ_IDX_W = 5;

  typedef enum logic [1:0] {
    CFG_ENABLE  = 2'd0,
    CFG_LEVEL   = 2'd1,
    CFG_SECURE  = 2'd2,
    CFG_SETPEND = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/riscv_irq_dispatcher_if.sv
// riscv_irq_dispatcher_if
// Configuration bus and core offer/acknowledge handshake of the dispatcher.
//   cfg_we_i / cfg_sel_i / cfg_idx_i / cfg_wdata_i : configuration write
//   irq_pending_o / irq_id_o / irq_lev_o / irq_sec_o : offer to the core
//   irq_ack_i / irq_ack_id_i                        : core acknowledge
// Modports: slave = dispatcher side, master = core/configuration side.
interface riscv_irq_dispatcher_if;
  import riscv_defines::*;

  logic                 cfg_we_i;
  logic [1:0]           cfg_sel_i;
  logic [IRQ_IDX_W-1:0] cfg_idx_i;
  logic [7:0]           cfg_wdata_i;

  logic                 irq_pending_o;
  logic [IRQ_ID_W-1:0]  irq_id_o;
  logic [IRQ_LEV_W-1:0] irq_lev_o;
  logic                 irq_sec_o;
  logic                 irq_ack_i;
  logic [IRQ_ID_W-1:0]  irq_ack_id_i;

  modport slave (
    input  cfg_we_i, cfg_sel_i, cfg_idx_i, cfg_wdata_i,
    input  irq_ack_i, irq_ack_id_i,
    output irq_pending_o, irq_id_o, irq_lev_o, irq_sec_o
  );

  modport master (
    output cfg_we_i, cfg_sel_i, cfg_idx_i, cfg_wdata_i,
    output irq_ack_i, irq_ack_id_i,
    input  irq_pending_o, irq_id_o, irq_lev_o, irq_sec_o
  );

endinterface

// File: rtl/riscv_irq_prio_tree.sv
// riscv_irq_prio_tree
// Combinational selection of the candidate line with the highest level;
// equal levels resolve to the lowest index.
//   cand_i  : candidate vector (already pending & enabled & level != 0)
//   lev_i   : per-line levels
//   valid_o : at least one candidate
//   idx_o   : winning line index
//   lev_o   : winning level
module riscv_irq_prio_tree
  import riscv_defines::*;
#(
  parameter int NUM_IRQ = 32
) (
  input  logic [NUM_IRQ-1:0]                cand_i,
  input  logic [NUM_IRQ-1:0][IRQ_LEV_W-1:0] lev_i,
  output logic                              valid_o,
  output logic [IRQ_IDX_W-1:0]              idx_o,
  output logic [IRQ_LEV_W-1:0]              lev_o
);

  logic                 best_v;
  logic [IRQ_IDX_W-1:0] best_idx;
  logic [IRQ_LEV_W-1:0] best_lev;

  // Scan upward; only a strictly higher level replaces the current best,
  // so the lowest index keeps a tie.
  always_comb begin
    best_v   = 1'b0;
    best_idx = '0;
    best_lev = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand_i[i] && (!best_v || (lev_i[i] > best_lev))) begin
        best_v   = 1'b1;
        best_idx = IRQ_IDX_W'(i);
        best_lev = lev_i[i];
      end
    end
  end

  assign valid_o = best_v;
  assign idx_o   = best_idx;
  assign lev_o   = best_lev;

endmodule

// File: rtl/riscv_irq_dispatcher.sv
// riscv_irq_dispatcher
// Edge-triggered interrupt collector with per-line enable/level, priority
// arbitration and a registered offer to the core.
//   clk, rst_n : clock, asynchronous active-low reset
//   irq_i      : interrupt lines, rising-edge triggered
//   bus        : riscv_irq_dispatcher_if.slave (cfg writes, offer, ack)
//   pending_o  : raw pending vector
// Optional feature: define IRQ_SECURE_EN for per-line secure bits
// (cfg_sel_i=2); otherwise irq_sec_o is tied to 1.
module riscv_irq_dispatcher
  import riscv_defines::*;
#(
  parameter int NUM_IRQ = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IRQ-1:0]       irq_i,
  riscv_irq_dispatcher_if.slave    bus,
  output logic [NUM_IRQ-1:0]       pending_o
);

  logic [NUM_IRQ-1:0]                pending_reg, pending_next;
  logic [NUM_IRQ-1:0]                enable_reg, enable_next;
  logic [NUM_IRQ-1:0]                irq_prev_reg;
  logic [NUM_IRQ-1:0][IRQ_LEV_W-1:0] level_reg, level_next;
  logic [NUM_IRQ-1:0]                cand;

  logic                 win_valid;
  logic [IRQ_IDX_W-1:0] win_idx;
  logic [IRQ_LEV_W-1:0] win_lev;

  irq_state_e           state_reg, state_next;
  logic [IRQ_ID_W-1:0]  id_reg;
  logic [IRQ_LEV_W-1:0] lev_reg;

  // Per-line next-state; out-of-range indices simply match no line.
  // Set terms are OR-ed after the ack clear so a same-cycle edge wins.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      logic line_sel;
      logic set_bit;
      logic clr_bit;

      assign line_sel = bus.cfg_we_i && (bus.cfg_idx_i == IRQ_IDX_W'(gi));
      assign set_bit  = (irq_i[gi] & ~irq_prev_reg[gi]) |
                        (line_sel && (bus.cfg_sel_i == CFG_SETPEND) && bus.cfg_wdata_i[0]);
      assign clr_bit  = bus.irq_ack_i && (bus.irq_ack_id_i == IRQ_ID_W'(gi));

      assign pending_next[gi] = (pending_reg[gi] & ~clr_bit) | set_bit;
      assign enable_next[gi]  = (line_sel && (bus.cfg_sel_i == CFG_ENABLE)) ?
                                bus.cfg_wdata_i[0] : enable_reg[gi];
      assign level_next[gi]   = (line_sel && (bus.cfg_sel_i == CFG_LEVEL)) ?
                                bus.cfg_wdata_i : level_reg[gi];
      assign cand[gi]         = pending_reg[gi] & enable_reg[gi] & (|level_reg[gi]);
    end
  endgenerate

  riscv_irq_prio_tree #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_tree (
    .cand_i  (cand),
    .lev_i   (level_reg),
    .valid_o (win_valid),
    .idx_o   (win_idx),
    .lev_o   (win_lev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= '0;
      enable_reg   <= '0;
      level_reg    <= '0;
      irq_prev_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      enable_reg   <= enable_next;
      level_reg    <= level_next;
      irq_prev_reg <= irq_i;
    end
  end

  // An ack always forces one HOLD cycle; otherwise every state follows
  // the presence of a candidate.
  always_comb begin
    state_next = state_reg;
    if (bus.irq_ack_i) begin
      state_next = ST_HOLD;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = win_valid ? ST_OFFER : ST_IDLE;
        ST_OFFER: state_next = win_valid ? ST_OFFER : ST_IDLE;
        ST_HOLD:  state_next = win_valid ? ST_OFFER : ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // id/lev reload only on entry to or stay in OFFER, so they keep the
  // last offered values in IDLE and HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      id_reg    <= '0;
      lev_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == ST_OFFER) begin
        id_reg  <= IRQ_ID_W'(win_idx);
        lev_reg <= win_lev;
      end
    end
  end

`ifdef IRQ_SECURE_EN
  logic [NUM_IRQ-1:0] secure_reg, secure_next;
  logic [NUM_IRQ-1:0] win_oh;
  logic               sec_reg;

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sec
      assign secure_next[gi] = (bus.cfg_we_i && (bus.cfg_sel_i == CFG_SECURE) &&
                                (bus.cfg_idx_i == IRQ_IDX_W'(gi))) ?
                               bus.cfg_wdata_i[0] : secure_reg[gi];
      assign win_oh[gi]      = (win_idx == IRQ_IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      secure_reg <= '1;
      sec_reg    <= 1'b1;
    end else begin
      secure_reg <= secure_next;
      if (state_next == ST_OFFER) begin
        sec_reg <= |(secure_reg & win_oh);
      end
    end
  end

  assign bus.irq_sec_o = sec_reg;
`else
  assign bus.irq_sec_o = 1'b1;
`endif

  assign bus.irq_pending_o = (state_reg == ST_OFFER);
  assign bus.irq_id_o      = id_reg;
  assign bus.irq_lev_o     = lev_reg;
  assign pending_o         = pending_reg;

endmodule

// File: tb/tb_riscv_irq_dispatcher.sv
// tb_riscv_irq_dispatcher
// Directed scenarios with literal expectations followed by randomized
// traffic; a behavioural model of the dispatcher is compared against the
// DUT on every falling clock edge.
module tb_riscv_irq_dispatcher;
  import riscv_defines::*;

  localparam int NUM = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NUM-1:0] irq = '0;
  logic [NUM-1:0] pending;

  riscv_irq_dispatcher_if bus ();

  riscv_irq_dispatcher #(
    .NUM_IRQ (NUM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_i     (irq),
    .bus       (bus),
    .pending_o (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit             m_pend [NUM];
  bit             m_en   [NUM];
  bit             m_secb [NUM];
  int             m_lev  [NUM];
  logic [NUM-1:0] m_prev;
  logic           e_pend;
  int             e_id;
  int             e_lev;
  logic           e_sec;

  always @(posedge clk or negedge rst_n) begin : model
    int maxl;
    int win;
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        m_pend[i] <= 1'b0;
        m_en[i]   <= 1'b0;
        m_lev[i]  <= 0;
        m_secb[i] <= 1'b1;
      end
      m_prev <= '0;
      e_pend <= 1'b0;
      e_id   <= 0;
      e_lev  <= 0;
      e_sec  <= 1'b1;
    end else begin
      // highest level among candidates, then lowest line holding it
      maxl = 0;
      for (int i = 0; i < NUM; i++)
        if (m_pend[i] && m_en[i] && m_lev[i] > maxl) maxl = m_lev[i];
      win = -1;
      if (maxl > 0)
        for (int i = NUM - 1; i >= 0; i--)
          if (m_pend[i] && m_en[i] && m_lev[i] == maxl) win = i;

      if (bus.irq_ack_i) begin
        e_pend <= 1'b0;
      end else if (win >= 0) begin
        e_pend <= 1'b1;
        e_id   <= win;
        e_lev  <= maxl;
`ifdef IRQ_SECURE_EN
        e_sec  <= m_secb[win];
`else
        e_sec  <= 1'b1;
`endif
      end else begin
        e_pend <= 1'b0;
      end

      for (int i = 0; i < NUM; i++) begin
        bit nv;
        nv = m_pend[i];
        if (bus.irq_ack_i && bus.irq_ack_id_i == i) nv = 1'b0;
        if (irq[i] && !m_prev[i]) nv = 1'b1;
        if (bus.cfg_we_i && bus.cfg_sel_i == 2'd3 && bus.cfg_idx_i == i && bus.cfg_wdata_i[0]) nv = 1'b1;
        m_pend[i] <= nv;
        if (bus.cfg_we_i && bus.cfg_idx_i == i) begin
          if (bus.cfg_sel_i == 2'd0) m_en[i]  <= bus.cfg_wdata_i[0];
          if (bus.cfg_sel_i == 2'd1) m_lev[i] <= int'(bus.cfg_wdata_i);
`ifdef IRQ_SECURE_EN
          if (bus.cfg_sel_i == 2'd2) m_secb[i] <= bus.cfg_wdata_i[0];
`endif
        end
      end
      m_prev <= irq;
    end
  end

  always @(negedge clk) begin : compare
    logic [NUM-1:0] exp_vec;
    if (cmp_en) begin
      for (int i = 0; i < NUM; i++) exp_vec[i] = m_pend[i];
      chk("irq_pending_o", 32'(bus.irq_pending_o), 32'(e_pend));
      chk("irq_id_o",      32'(bus.irq_id_o),      32'(e_id));
      chk("irq_lev_o",     32'(bus.irq_lev_o),     32'(e_lev));
      chk("irq_sec_o",     32'(bus.irq_sec_o),     32'(e_sec));
      chk("pending_o",     32'(pending),           32'(exp_vec));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg(input int sel, input int idx, input int data);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_sel_i   = 2'(sel);
    bus.cfg_idx_i   = 5'(idx);
    bus.cfg_wdata_i = 8'(data);
    @(negedge clk);
    bus.cfg_we_i    = 1'b0;
    $display("cfg   sel=%0d idx=%0d data=%0h", sel, idx, data);
  endtask

  task automatic pulse(input int line);
    irq[line] = 1'b1;
    @(negedge clk);
    irq[line] = 1'b0;
    $display("edge  line=%0d", line);
  endtask

  task automatic ack(input int id);
    bus.irq_ack_i    = 1'b1;
    bus.irq_ack_id_i = 10'(id);
    @(negedge clk);
    bus.irq_ack_i    = 1'b0;
    $display("ack   id=%0d", id);
  endtask

  task automatic do_reset();
    irq = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset");
  endtask

  task automatic expect_offer(input string tag, input logic p, input int id, input int lev);
    chk({tag, ".pend"}, 32'(bus.irq_pending_o), 32'(p));
    chk({tag, ".id"},   32'(bus.irq_id_o),      32'(id));
    chk({tag, ".lev"},  32'(bus.irq_lev_o),     32'(lev));
  endtask

  initial begin
    bus.cfg_we_i     = 1'b0;
    bus.cfg_sel_i    = '0;
    bus.cfg_idx_i    = '0;
    bus.cfg_wdata_i  = '0;
    bus.irq_ack_i    = 1'b0;
    bus.irq_ack_id_i = '0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    expect_offer("reset", 1'b0, 0, 0);
    chk("reset.pending", 32'(pending), 32'h0);
    chk("reset.sec", 32'(bus.irq_sec_o), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // single line edge
    cfg(0, 5, 1);
    cfg(1, 5, 3);
    pulse(5);
    chk("s1.pending5", 32'(pending[5]), 32'h1);
    chk("s1.not_yet", 32'(bus.irq_pending_o), 32'h0);
    @(negedge clk);
    expect_offer("s1", 1'b1, 5, 3);

    // equal levels: lowest index first, ack -> one HOLD cycle
    do_reset();
    cfg(0, 2, 1); cfg(1, 2, 4);
    cfg(0, 9, 1); cfg(1, 9, 4);
    irq[2] = 1'b1; irq[9] = 1'b1;
    @(negedge clk);
    irq = '0;
    @(negedge clk);
    expect_offer("s2", 1'b1, 2, 4);
    ack(2);
    expect_offer("s2.hold", 1'b0, 2, 4);
    chk("s2.pending", 32'(pending), 32'h0200);
    @(negedge clk);
    expect_offer("s2.next", 1'b1, 9, 4);

    // preemption by higher level
    do_reset();
    cfg(0, 1, 1); cfg(1, 1, 2);
    cfg(0, 7, 1); cfg(1, 7, 6);
    pulse(1);
    @(negedge clk);
    expect_offer("s3.first", 1'b1, 1, 2);
    pulse(7);
    @(negedge clk);
    expect_offer("s3.preempt", 1'b1, 7, 6);

    // edge on the acked line in the ack cycle
    do_reset();
    cfg(0, 3, 1); cfg(1, 3, 1);
    pulse(3);
    @(negedge clk);
    expect_offer("s4.offer", 1'b1, 3, 1);
    irq[3] = 1'b1;
    ack(3);
    irq[3] = 1'b0;
    chk("s4.kept", 32'(pending[3]), 32'h1);
    chk("s4.hold", 32'(bus.irq_pending_o), 32'h0);
    @(negedge clk);
    expect_offer("s4.reoffer", 1'b1, 3, 1);

    // disable offered line, then out-of-range ack
    cfg(0, 3, 0);
    @(negedge clk);
    expect_offer("s5.disabled", 1'b0, 3, 1);
    cfg(0, 3, 1);
    @(negedge clk);
    chk("s5.back", 32'(bus.irq_pending_o), 32'h1);
    ack(40);
    chk("s5.hold40", 32'(bus.irq_pending_o), 32'h0);
    chk("s5.pending40", 32'(pending), 32'h0008);
    @(negedge clk);
    expect_offer("s5.reoffer", 1'b1, 3, 1);

    // software set-pending, no-op set, out-of-range cfg index, level 0
    do_reset();
    cfg(0, 6, 1); cfg(1, 6, 2);
    cfg(3, 8, 0);
    cfg(3, 20, 1);
    cfg(0, 10, 1);
    pulse(10);
    cfg(3, 6, 1);
    chk("s6.pending", 32'(pending), 32'h0440);
    @(negedge clk);
    expect_offer("s6.sw", 1'b1, 6, 2);

    // secure flag of the offered line
    do_reset();
`ifdef IRQ_SECURE_EN
    cfg(2, 4, 0);
`endif
    cfg(0, 4, 1); cfg(1, 4, 5);
    pulse(4);
    @(negedge clk);
    expect_offer("s7", 1'b1, 4, 5);
`ifdef IRQ_SECURE_EN
    chk("s7.sec", 32'(bus.irq_sec_o), 32'h0);
`else
    chk("s7.sec", 32'(bus.irq_sec_o), 32'h1);
`endif

    // asynchronous reset while offering
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.pend", 32'(bus.irq_pending_o), 32'h0);
    chk("areset.pending", 32'(pending), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset mid-offer");

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      irq = irq ^ NUM'($urandom & $urandom & $urandom);
      bus.cfg_we_i  = ($urandom_range(0, 3) == 0);
      bus.cfg_sel_i = 2'($urandom_range(0, 3));
      bus.cfg_idx_i = 5'($urandom_range(0, 31));
      if (bus.cfg_sel_i == 2'd1)
        bus.cfg_wdata_i = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      else
        bus.cfg_wdata_i = 8'($urandom_range(0, 255)) | 8'(($urandom_range(0, 3) != 0) ? 1 : 0);
      bus.irq_ack_i    = ($urandom_range(0, 7) == 0);
      bus.irq_ack_id_i = ($urandom_range(0, 1) == 0) ? 10'(e_id) : 10'($urandom_range(0, 40));
      @(negedge clk);
    end
    bus.cfg_we_i  = 1'b0;
    bus.irq_ack_i = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_irq_dispatcher.md
RISCV_IRQ_DISPATCHER -- requirements
Module: riscv_irq_dispatcher

Interface
REQ-001 Parameter NUM_IRQ, default 32, number of interrupt lines; legal range 2..32.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 irq_i  input  NUM_IRQ  synchronous interrupt lines, rising-edge triggered.
REQ-005 cfg_we_i  input  1  configuration write strobe.
REQ-006 cfg_sel_i  input  2  target: 0 enable, 1 level, 2 secure, 3 set-pending.
REQ-007 cfg_idx_i  input  5  line index.
REQ-008 cfg_wdata_i  input  8  write data; bit 0 for enable, secure and set-pending.
REQ-009 irq_pending_o  output  1  request to core interrupt controller.
REQ-010 irq_id_o  output  10  id of offered line, zero-extended.
REQ-011 irq_lev_o  output  8  level of offered line.
REQ-012 irq_sec_o  output  1  secure (machine) flag of offered line.
REQ-013 irq_ack_i  input  1  core acknowledge, single-cycle pulse.
REQ-014 irq_ack_id_i  input  10  id being acknowledged.
REQ-015 pending_o  output  NUM_IRQ  raw pending vector, for debug/readback.

Function
REQ-016 Line k edge: irq_i[k]=1 at a sampling edge with the previous sample 0; pending[k] sets at that same edge.
REQ-017 cfg_sel_i=3 write with wdata[0]=1 sets pending[cfg_idx_i]; wdata[0]=0 has no effect.
REQ-018 Candidate: pending & enable & level!=0; level-0 lines never offered.
REQ-019 Arbitration: highest level wins; tie goes to lowest index; the priority tree is combinational.
REQ-020 Outputs are registered and take the arbitration result one cycle after pending/config changes.
REQ-021 FSM states: IDLE (no candidate, irq_pending_o=0), OFFER (irq_pending_o=1), HOLD (irq_pending_o=0).
REQ-022 IDLE->OFFER when a candidate exists.
REQ-023 OFFER->IDLE when no candidate remains (line disabled or level set 0); id/lev/sec retain their last values.
REQ-024 In OFFER, id/lev/sec re-evaluate every cycle; preemption by a higher-level line is allowed.
REQ-025 irq_ack_i in any state clears pending[irq_ack_id_i] and enters HOLD for exactly one cycle, then IDLE or OFFER per candidates.
REQ-026 Ack with irq_ack_id_i>=NUM_IRQ clears nothing but still enters HOLD.
REQ-027 An edge or software set on the acked line in the same cycle as the ack wins; that line stays pending.
REQ-028 Out-of-range cfg_idx_i (>=NUM_IRQ) writes are ignored.
REQ-029 A core kill without ack leaves pending untouched; the line is re-offered.

Reset
REQ-030 Reset value 0 for: pending, enable, level, edge-sample registers, irq_pending_o, irq_id_o, irq_lev_o, pending_o.
REQ-031 Reset state is IDLE; irq_sec_o resets per REQ-033/034.
REQ-032 Reset asserted mid-OFFER drops irq_pending_o immediately (asynchronous reset).

Configuration
REQ-033 With IRQ_SECURE_EN defined: per-line secure bits are writable via cfg_sel_i=2, reset to 1; irq_sec_o carries the offered line's bit and resets to 1.
REQ-034 Without IRQ_SECURE_EN: no secure storage; cfg_sel_i=2 writes are ignored; irq_sec_o is constant 1 (all interrupts machine-level).

Structure
REQ-035 The cfg selector enum and the IRQ_ID_W=10 constant are placed in riscv_defines.
REQ-036 The max-level/lowest-index tree is one sub-module, riscv_irq_prio_tree, parameterised by NUM_IRQ.

Verification
REQ-037 Scenario: enable line 5, level 3, pulse irq_i[5] -> pending[5] set at the sampling edge; next cycle irq_pending_o=1, id=5, lev=3.
REQ-038 Scenario: lines 2 and 9 both at level 4, same-cycle edges -> id=2; ack id 2 -> 1-cycle HOLD, then id=9.
REQ-039 Scenario: line 1 at level 2 offered, line 7 at level 6 edges -> next cycle id=7, lev=6.
REQ-040 Scenario: ack id 3 and irq_i[3] edge in the same cycle -> pending[3] stays 1, re-offered after HOLD.
REQ-041 Scenario: offered line disabled via cfg -> irq_pending_o=0 the next cycle; ack id 40 -> no pending change, HOLD once.
REQ-042 Scenario: IRQ_SECURE_EN defined, secure[4]=0, line 4 offered -> irq_sec_o=0; build without the macro -> irq_sec_o=1 always.
